// File: rtl/mem_pkg.sv
// Shared memory-system constants and bank decode, also used by the cache
// controller's burst address generator.
package mem_pkg;

  localparam int unsigned NUM_BANKS         = 4;
  localparam int unsigned BANK_SEL_LO       = 1;
  localparam int unsigned BANK_BUSY_DEFAULT = 4;

  function automatic logic [1:0] bank_of(input logic [2:0] addr_lo);
    return addr_lo[BANK_SEL_LO +: 2];
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One interleaved memory bank: word storage, registered read sample and
// the recovery counter that keeps the bank busy after each access.
module mem_bank #(
  parameter int unsigned ROW_W     = 13,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BANK_BUSY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam logic [1:0] BUSY_LOAD = 2'(BANK_BUSY - 1);

  logic [DATA_W-1:0] mem [2**ROW_W];
  logic [1:0]        cnt;

  // Storage is deliberately outside reset so written words survive it.
  always_ff @(posedge clk) begin
    if (we) mem[row] <= wdata;
    if (re) rdata    <= mem[row];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (we || re)   cnt <= BUSY_LOAD;
    else if (cnt != '0)  cnt <= cnt - 2'd1;
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/four_bank_mem.sv
// Four-bank interleaved main memory behind the cache controller: request
// decode, error/stall generation and the two-cycle read return path.
module four_bank_mem
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BANK_BUSY = BANK_BUSY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd,
  input  logic                 wr,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    data_in,
  output logic [DATA_W-1:0]    data_out,
  output logic                 rd_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int unsigned ROW_W = ADDR_W - 3;

  logic                 req;
  logic                 accept;
  logic [1:0]           bank;
  logic [ROW_W-1:0]     row;
  logic [NUM_BANKS-1:0] bank_we;
  logic [NUM_BANKS-1:0] bank_re;
  logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];
  logic                 s1_valid;
  logic [1:0]           s1_bank;

  assign req    = rd | wr;
  assign bank   = bank_of(addr[2:0]);
  assign row    = addr[ADDR_W-1:3];
  assign err    = (rd & wr) | (req & addr[0]);
  assign stall  = req & busy[bank] & ~err;
  assign accept = req & ~stall & ~err;

  always_comb begin
    bank_we = '0;
    bank_re = '0;
    if (accept) begin
      bank_we[bank] = wr;
      bank_re[bank] = rd;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    mem_bank #(
      .ROW_W     (ROW_W),
      .DATA_W    (DATA_W),
      .BANK_BUSY (BANK_BUSY)
    ) u_bank (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (bank_we[b]),
      .re    (bank_re[b]),
      .row   (row),
      .wdata (data_in),
      .rdata (bank_rdata[b]),
      .busy  (busy[b])
    );
  end

  // The bank's own read register is stage 1; only its valid/bank tag lives here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_bank  <= '0;
      rd_valid <= 1'b0;
      data_out <= '0;
    end else begin
      s1_valid <= accept & rd;
      s1_bank  <= bank;
      rd_valid <= s1_valid;
      data_out <= s1_valid ? bank_rdata[s1_bank] : '0;
    end
  end

endmodule

// File: tb/tb_four_bank_mem.sv
// Directed bench for four_bank_mem: a word model and a read scoreboard with
// due cycles check data, latency, stalls, errors and reset behaviour.
module tb_four_bank_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  bit   [15:0] model [bit [15:0]];

  four_bank_mem #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .BANK_BUSY (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read return monitor: every rd_valid must match the oldest expected read.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (rd_valid) begin
        if (sb.size() == 0) begin
          check("rd_valid_unexpected", 32'(rd_valid), 32'(1'b0));
        end else begin
          e = sb.pop_front();
          check("rd_latency", 32'(cyc), 32'(e.due));
          check("rd_data", 32'(data_out), 32'(e.data));
        end
      end else begin
        check("data_out_idle", 32'(data_out), 32'h0);
        if (sb.size() != 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          check("rd_missing", 32'(rd_valid), 32'(1'b1));
        end
      end
    end
  end

  task automatic step(input logic r, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input logic es, input logic ee);
    int c;
    rd = r; wr = w; addr = a; data_in = d;
    @(negedge clk);
    c = cyc;
    check("stall", 32'(stall), 32'(es));
    check("err", 32'(err), 32'(ee));
    if (es) check("busy_bank", 32'(busy[a[2:1]]), 32'(1'b1));
    if ((r || w) && !es && !ee) begin
      if (w) model[a] = d;
      if (r) sb.push_back('{data: (model.exists(a) ? model[a] : 16'h0), due: c + 2});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single write then read-back
    step(1'b0, 1'b1, 16'h1234, 16'hBEEF, 1'b0, 1'b0);
    repeat (4) idle();
    step(1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0);
    repeat (3) idle();

    // preload then a four-bank read burst
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 16'(16'h0040 + 2 * i), 16'(16'h1111 * (i + 1)), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 16'(16'h0040 + 2 * i), 16'h0000, 1'b0, 1'b0);
    repeat (4) idle();

    // same-bank reissue stalls for BANK_BUSY-1 cycles
    step(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 16'h0018, 16'h0000, 1'b1, 1'b0);
    step(1'b1, 1'b0, 16'h0018, 16'h0000, 1'b0, 1'b0);
    repeat (4) idle();

    // illegal requests: no access, no busy, no array change
    step(1'b1, 1'b1, 16'h0020, 16'hFFFF, 1'b0, 1'b1);
    step(1'b1, 1'b0, 16'h0021, 16'h0000, 1'b0, 1'b1);
    check("err_busy", 32'(busy), 32'h0);
    step(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0);
    repeat (4) idle();

    // reset in the middle of a read
    step(1'b0, 1'b1, 16'h000A, 16'h5A5A, 1'b0, 1'b0);
    repeat (4) idle();
    rd = 1'b1; wr = 1'b0; addr = 16'h0002;
    #1 check("pre_rst_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1 rd = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_rd_valid", 32'(rd_valid), 32'h1);
    check("pre_rst_busy", 32'(busy), 32'h2);
    rst_n = 1'b0;
    #1;
    check("async_rst_rd_valid", 32'(rd_valid), 32'h0);
    check("async_rst_data_out", 32'(data_out), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 16'h000A, 16'h0000, 1'b0, 1'b0);
    repeat (3) idle();

    // dirty write-back burst followed by a fill of the same line
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 16'(16'h0F80 + 2 * i), 16'(16'hD001 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 16'(16'h0F80 + 2 * i), 16'h0000, 1'b0, 1'b0);
    repeat (4) idle();

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
